// File: rtl/uart_msg_sched_pkg.sv
// Shared constants and types for the stopwatch UART message scheduler.
//   - ASCII punctuation/control bytes and the digit base used in frames
//   - frame length and the index of its last byte
//   - FSM state encoding (2 bits)
package uart_msg_sched_pkg;

  localparam logic [7:0] ASCII_COLON  = 8'h3A;
  localparam logic [7:0] ASCII_DOT    = 8'h2E;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT0 = 8'h30;

  localparam int         FRAME_LEN = 11;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_msg_sched_if.sv
// Signal bundle between the stopwatch logic / uart_tx and the scheduler.
//   master : the scheduler (consumes requests and tx_done_tick, drives the
//            transmitter start/data and status pulses, exposes its state)
//   slave  : the surrounding logic (requesters + transmitter)
//
// Transmitter handshake: tx_start is an active-low level held low for
// exactly one cycle with tx_data valid in that same cycle; tx_data stays
// stable until the transmitter answers with a one-cycle tx_done_tick at
// the end of the stop bit. Only then may the next start be issued.
interface uart_msg_sched_if;
  import uart_msg_sched_pkg::*;

  logic        tick_req;
  logic        lap_req;
  logic [23:0] time_bcd;
  logic        tx_done_tick;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done;
  logic [1:0]  drop;
  state_t      state;

  modport master (
    input  tick_req, lap_req, time_bcd, tx_done_tick,
    output tx_start, tx_data, busy, frame_done, drop, state
  );

  modport slave (
    output tick_req, lap_req, time_bcd, tx_done_tick,
    input  tx_start, tx_data, busy, frame_done, drop, state
  );
endinterface

// File: rtl/uart_msg_sched_bcd_to_ascii.sv
// Combinational BCD nibble to ASCII digit conversion.
//   nibble : 4-bit BCD digit
//   ascii  : '0'..'9', or BAD_DIGIT for nibble values 10..15
module uart_msg_sched_bcd_to_ascii
  import uart_msg_sched_pkg::*;
#(
  parameter logic [7:0] BAD_DIGIT = 8'h3F
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = (nibble > 4'd9) ? BAD_DIGIT : (ASCII_DIGIT0 + {4'd0, nibble});

endmodule

// File: rtl/uart_msg_sched.sv
// Stopwatch UART message scheduler.
// Two requesters (periodic report, lap) each own a one-entry snapshot
// buffer; lap wins arbitration. The selected snapshot is sent as the
// 11-byte frame "<P>MM:SS.CC\r\n" through the uart_tx start/done handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : requests, time snapshot, transmitter handshake, status
//                pulses (busy, frame_done, drop) and FSM state for debug
module uart_msg_sched
  import uart_msg_sched_pkg::*;
#(
  parameter logic [7:0] PREFIX_T  = 8'h54,
  parameter logic [7:0] PREFIX_L  = 8'h4C,
  parameter logic [7:0] BAD_DIGIT = 8'h3F
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_msg_sched_if.master   bus
);

  state_t      state, state_d;
  logic [3:0]  idx, idx_d;

  logic        tick_pend, lap_pend;
  logic [23:0] tick_snap, lap_snap;
  logic [23:0] work_snap;
  logic [7:0]  work_prefix;

  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [1:0]  drop_q;

  logic        sel_lap, sel_tick, load_work;
  logic [3:0]  nibble;
  logic [7:0]  digit_ascii;
  logic [7:0]  frame_byte;

  // Arbitration happens only in IDLE; a selected buffer is released in
  // the same cycle its contents move to the working register.
  always_comb begin
    sel_lap   = (state == ST_IDLE) && lap_pend;
    sel_tick  = (state == ST_IDLE) && tick_pend && !lap_pend;
    load_work = sel_lap || sel_tick;
  end

  // Digit positions of the frame map onto the six snapshot nibbles.
  always_comb begin
    nibble = 4'd0;
    case (idx)
      4'd1:    nibble = work_snap[23:20];
      4'd2:    nibble = work_snap[19:16];
      4'd4:    nibble = work_snap[15:12];
      4'd5:    nibble = work_snap[11:8];
      4'd7:    nibble = work_snap[7:4];
      4'd8:    nibble = work_snap[3:0];
      default: nibble = 4'd0;
    endcase
  end

  uart_msg_sched_bcd_to_ascii #(.BAD_DIGIT(BAD_DIGIT)) u_bcd_to_ascii (
    .nibble (nibble),
    .ascii  (digit_ascii)
  );

  always_comb begin
    frame_byte = digit_ascii;
    case (idx)
      4'd0:    frame_byte = work_prefix;
      4'd3:    frame_byte = ASCII_COLON;
      4'd6:    frame_byte = ASCII_DOT;
      4'd9:    frame_byte = ASCII_CR;
      4'd10:   frame_byte = ASCII_LF;
      default: frame_byte = digit_ascii;
    endcase
  end

  // Next-state and next-output logic. Outputs are registered, so the
  // start pulse computed while in ISSUE appears on the pins during the
  // first WAIT cycle.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    busy_d       = busy_q;
    tx_start_d   = 1'b1;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_work) begin
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tx_start_d = 1'b0;
        tx_data_d  = frame_byte;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.tx_done_tick) begin
          if (idx < LAST_IDX) begin
            idx_d   = idx + 4'd1;
            state_d = ST_ISSUE;
          end else begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        idx_d   = 4'd0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= 4'd0;
      tx_start_q   <= 1'b1;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Request buffers and working snapshot. A new request always wins over
  // the release, so a request landing on the release cycle refills the
  // buffer without counting as an overwrite.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_pend   <= 1'b0;
      lap_pend    <= 1'b0;
      tick_snap   <= 24'd0;
      lap_snap    <= 24'd0;
      work_snap   <= 24'd0;
      work_prefix <= 8'd0;
      drop_q      <= 2'b00;
    end else begin
      if (load_work) begin
        work_snap   <= sel_lap ? lap_snap : tick_snap;
        work_prefix <= sel_lap ? PREFIX_L : PREFIX_T;
      end

      if (bus.tick_req) begin
        tick_pend <= 1'b1;
        tick_snap <= bus.time_bcd;
      end else if (sel_tick) begin
        tick_pend <= 1'b0;
      end

      if (bus.lap_req) begin
        lap_pend <= 1'b1;
        lap_snap <= bus.time_bcd;
      end else if (sel_lap) begin
        lap_pend <= 1'b0;
      end

      drop_q <= {bus.lap_req && lap_pend && !sel_lap,
                 bus.tick_req && tick_pend && !sel_tick};
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.drop       = drop_q;
  assign bus.state      = state;

endmodule
